// File: rtl/fpu_result_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_queue_if
// Description : Handshake, status and control bundle for the FPU result queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_result_queue_if #(
    parameter int BIT_WIDTH  = 128,
    parameter int ADDR_WIDTH = 2
);
    logic                  i_valid;
    logic [BIT_WIDTH-1:0]  i_result;
    logic [4:0]            i_flags;
    logic                  o_ready;
    logic                  o_valid;
    logic [BIT_WIDTH-1:0]  o_result;
    logic [4:0]            o_flags;
    logic                  i_ready;
    logic                  i_clr_sticky;
    logic [4:0]            i_flag_mask;
    logic [4:0]            o_sticky;
    logic                  o_overrun;
    logic                  o_irq;
    logic [ADDR_WIDTH:0]   o_count;

    modport slave (
        input  i_valid, i_result, i_flags, i_ready, i_clr_sticky, i_flag_mask,
        output o_ready, o_valid, o_result, o_flags, o_sticky, o_overrun, o_irq, o_count
    );

    modport master (
        output i_valid, i_result, i_flags, i_ready, i_clr_sticky, i_flag_mask,
        input  o_ready, o_valid, o_result, o_flags, o_sticky, o_overrun, o_irq, o_count
    );
endinterface
`default_nettype wire

// File: rtl/fpu_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_queue
// Description : FWFT result/flag FIFO with sticky IEEE exception status and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_queue #(
    parameter int BIT_WIDTH  = 128,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_result_queue_if.slave    bus
);
    localparam int                  c_ENTRY_W = BIT_WIDTH + 5;
    localparam int                  c_DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_FULL    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [c_ENTRY_W-1:0]  r_mem [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [4:0]            r_sticky;
    logic                  r_overrun;

    logic                  w_ready;
    logic                  w_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic [c_ENTRY_W-1:0]  w_head;

    // Ready depends only on the registered count, never on the consumer's ready.
    assign w_ready = (r_count != c_FULL);
    assign w_valid = (r_count != '0);
    assign w_push  = bus.i_valid && w_ready;
    assign w_pop   = w_valid && bus.i_ready;
    assign w_drop  = bus.i_valid && !w_ready;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.i_flags, bus.i_result};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A fresh event in the clear cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (bus.i_clr_sticky) begin
                r_sticky <= w_push ? bus.i_flags : 5'b0;
            end else if (w_push) begin
                r_sticky <= r_sticky | bus.i_flags;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.i_clr_sticky) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.o_ready   = w_ready;
    assign bus.o_valid   = w_valid;
    assign bus.o_result  = w_head[BIT_WIDTH-1:0];
    assign bus.o_flags   = w_head[c_ENTRY_W-1:BIT_WIDTH];
    assign bus.o_count   = r_count;
    assign bus.o_sticky  = r_sticky;
    assign bus.o_overrun = r_overrun;
    assign bus.o_irq     = (|(r_sticky & ~bus.i_flag_mask)) | r_overrun;
endmodule
`default_nettype wire
